// File: rtl/wb_sram_target_pkg.sv
//------------------------------------------------------------------------------
// Module      : wb_sram_target_pkg
// Description : Shared FSM encoding, counter width and index helper.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_sram_target_pkg;

    localparam int c_wait_cnt_w = 4;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    // Byte address to word index shift: log2 of the lane count.
    function automatic int index_shift(input int dat_width);
        return $clog2(dat_width / 8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_sram_target_mem.sv
//------------------------------------------------------------------------------
// Module      : wb_sram_target_mem
// Description : Single-port RAM, per-lane write enables, registered read.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_sram_target_mem #(
    parameter int DEPTH     = 1024,
    parameter int DAT_WIDTH = 32,
    parameter int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic                   i_we,
    input  logic                   i_clr,
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic [DAT_WIDTH-1:0]   i_wdata,
    input  logic [DAT_WIDTH/8-1:0] i_sel,
    output logic [DAT_WIDTH-1:0]   o_rdata
);

    logic [DAT_WIDTH-1:0] r_mem [DEPTH];
    logic [DAT_WIDTH-1:0] r_rdata;
    logic [DAT_WIDTH-1:0] w_mask;

    genvar g;
    generate
        for (g = 0; g < DAT_WIDTH / 8; g++) begin : g_lane
            assign w_mask[g*8 +: 8] = {8{i_sel[g]}};
        end
    endgenerate

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= (r_mem[i_addr] & ~w_mask) | (i_wdata & w_mask);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_clr) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/wb_sram_target.sv
//------------------------------------------------------------------------------
// Module      : wb_sram_target
// Description : Wishbone classic target with wait states and range error.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_sram_target
    import wb_sram_target_pkg::*;
#(
    parameter int ADR_WIDTH   = 32,
    parameter int DAT_WIDTH   = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADR_WIDTH-1:0]   adr,
    input  logic [DAT_WIDTH-1:0]   dat_w,
    output logic [DAT_WIDTH-1:0]   dat_r,
    input  logic                   cyc,
    input  logic                   stb,
    input  logic                   we,
    input  logic [DAT_WIDTH/8-1:0] sel,
    output logic                   ack,
    output logic                   err
);

    localparam int c_nlanes = DAT_WIDTH / 8;
    localparam int c_shift  = index_shift(DAT_WIDTH);
    localparam int c_mem_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]              r_state;
    logic [c_wait_cnt_w-1:0] r_cnt;
    logic                    r_ack;
    logic                    r_err;
    logic [c_mem_aw-1:0]     r_idx;
    logic                    r_oor;
    logic                    r_we;
    logic [c_nlanes-1:0]     r_sel;
    logic [DAT_WIDTH-1:0]    r_dat;

    logic [ADR_WIDTH-1:0]    w_idx;
    logic                    w_in_oor;
    logic                    w_sample;
    logic                    w_go;
    logic                    w_from_bus;
    logic [c_mem_aw-1:0]     w_acc_idx;
    logic                    w_acc_oor;
    logic                    w_acc_we;
    logic [c_nlanes-1:0]     w_acc_sel;
    logic [DAT_WIDTH-1:0]    w_acc_dat;

    assign w_idx    = adr >> c_shift;
    assign w_in_oor = 64'(w_idx) >= 64'(DEPTH);
    assign w_sample = (r_state == c_st_idle) && cyc && stb;

    // With no wait states the access happens on the sampling edge itself,
    // so the live bus fields are used instead of the capture registers.
    assign w_from_bus = (r_state == c_st_idle);
    assign w_go       = (w_sample && (WAIT_STATES == 0))
                     || ((r_state == c_st_wait) && cyc && (r_cnt == '0));

    assign w_acc_idx = w_from_bus ? w_idx[c_mem_aw-1:0] : r_idx;
    assign w_acc_oor = w_from_bus ? w_in_oor : r_oor;
    assign w_acc_we  = w_from_bus ? we       : r_we;
    assign w_acc_sel = w_from_bus ? sel      : r_sel;
    assign w_acc_dat = w_from_bus ? dat_w    : r_dat;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_oor   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_dat   <= '0;
        end else begin
            r_ack <= w_go && !w_acc_oor;
            r_err <= w_go && w_acc_oor;
            case (r_state)
                c_st_idle: begin
                    if (w_sample) begin
                        r_idx <= w_idx[c_mem_aw-1:0];
                        r_oor <= w_in_oor;
                        r_we  <= we;
                        r_sel <= sel;
                        r_dat <= dat_w;
                        if (WAIT_STATES == 0) begin
                            r_state <= c_st_resp;
                        end else begin
                            r_state <= c_st_wait;
                            r_cnt   <= c_wait_cnt_w'(WAIT_STATES - 1);
                        end
                    end
                end
                c_st_wait: begin
                    if (!cyc) begin
                        r_state <= c_st_idle;
                    end else if (r_cnt == '0) begin
                        r_state <= c_st_resp;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_st_resp: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    wb_sram_target_mem #(
        .DEPTH     (DEPTH),
        .DAT_WIDTH (DAT_WIDTH),
        .ADDR_W    (c_mem_aw)
    ) u_mem (
        .clk     (clock),
        .rst     (reset),
        .i_en    (w_go && !w_acc_oor),
        .i_we    (w_acc_we),
        .i_clr   (w_go && w_acc_oor),
        .i_addr  (w_acc_idx),
        .i_wdata (w_acc_dat),
        .i_sel   (w_acc_sel),
        .o_rdata (dat_r)
    );

    assign ack = r_ack;
    assign err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_wb_sram_target.sv
//------------------------------------------------------------------------------
// Module      : tb_wb_sram_target
// Description : Directed bench over four targets with 0/3/5/4 wait states.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_sram_target;

    localparam int c_nd = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] adr   [c_nd];
    logic [31:0] dat_w [c_nd];
    logic [31:0] dat_r [c_nd];
    logic        cyc   [c_nd];
    logic        stb   [c_nd];
    logic        we    [c_nd];
    logic [3:0]  sel   [c_nd];
    logic        ack   [c_nd];
    logic        err   [c_nd];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    genvar g;
    generate
        for (g = 0; g < c_nd; g++) begin : g_dut
            wb_sram_target #(
                .ADR_WIDTH   (32),
                .DAT_WIDTH   (32),
                .DEPTH       (1024),
                .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 5 : 4)
            ) u_dut (
                .clock (clock),
                .reset (reset),
                .adr   (adr[g]),
                .dat_w (dat_w[g]),
                .dat_r (dat_r[g]),
                .cyc   (cyc[g]),
                .stb   (stb[g]),
                .we    (we[g]),
                .sel   (sel[g]),
                .ack   (ack[g]),
                .err   (err[g])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // One request; lat counts cycles from the sampling edge to the edge
    // at which the initiator sees ack/err (1 for zero wait states).
    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] dw, input logic [3:0] s,
                        output logic [31:0] rd, output int lat,
                        output logic ga, output logic ge);
        @(negedge clock);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
        adr[d] = a; dat_w[d] = dw; sel[d] = s;
        @(posedge clock);
        lat = 1;
        #1;
        while (!(ack[d] || err[d]) && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        rd = dat_r[d]; ga = ack[d]; ge = err[d];
        @(negedge clock);
        cyc[d] = 1'b0; stb[d] = 1'b0;
        @(posedge clock); #1;
        check("pulse_one_cycle", {62'd0, ack[d], err[d]}, 64'd0);
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] dw,
                      input logic [3:0] s, input int el);
        logic [31:0] rd; int lat; logic ga, ge;
        xfer(d, 1'b1, a, dw, s, rd, lat, ga, ge);
        check("wr_ack", ga, 1);
        check("wr_err", ge, 0);
        check("wr_latency", lat, el);
    endtask

    task automatic rdchk(input int d, input logic [31:0] a, input logic [31:0] ed, input int el);
        logic [31:0] rd; int lat; logic ga, ge;
        xfer(d, 1'b0, a, 32'h0, 4'hF, rd, lat, ga, ge);
        check("rd_ack", ga, 1);
        check("rd_err", ge, 0);
        check("rd_latency", lat, el);
        check("rd_data", rd, ed);
    endtask

    initial begin
        int t [3];
        int nacks, cyc_i, dbl, seen;
        logic prev;
        logic [31:0] rd; int lat; logic ga, ge;

        for (int i = 0; i < c_nd; i++) begin
            adr[i] = '0; dat_w[i] = '0; cyc[i] = 1'b0;
            stb[i] = 1'b0; we[i] = 1'b0; sel[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < c_nd; i++) begin
            check("reset_ack", ack[i], 0);
            check("reset_err", err[i], 0);
            check("reset_dat_r", dat_r[i], 0);
        end
        @(negedge clock);
        reset = 1'b0;

        // Zero wait states: write then read
        wr(0, 32'h10, 32'hDEADBEEF, 4'hF, 1);
        rdchk(0, 32'h10, 32'hDEADBEEF, 1);
        rdchk(0, 32'h13, 32'hDEADBEEF, 1);

        // Byte lanes
        wr(0, 32'h20, 32'h11223344, 4'hF, 1);
        wr(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1);
        rdchk(0, 32'h20, 32'h11BB33DD, 1);
        wr(0, 32'h20, 32'hFFFFFFFF, 4'b0000, 1);
        rdchk(0, 32'h20, 32'h11BB33DD, 1);

        // Out of range and top in-range word
        wr(0, 32'h0, 32'h0BADCAFE, 4'hF, 1);
        wr(0, 32'hFFC, 32'h600DF00D, 4'hF, 1);
        rdchk(0, 32'hFFC, 32'h600DF00D, 1);
        xfer(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, rd, lat, ga, ge);
        check("oor_err", ge, 1);
        check("oor_ack", ga, 0);
        check("oor_latency", lat, 1);
        check("oor_dat_r", rd, 0);
        rdchk(0, 32'h0, 32'h0BADCAFE, 1);

        // Three wait states: single read, then held strobe
        wr(1, 32'h10, 32'h12345678, 4'hF, 4);
        rdchk(1, 32'h10, 32'h12345678, 4);
        @(negedge clock);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h10; sel[1] = 4'hF;
        nacks = 0; cyc_i = 0; dbl = 0; prev = 1'b0;
        while (nacks < 3 && cyc_i < 60) begin
            @(posedge clock); #1;
            cyc_i++;
            if (ack[1]) begin
                if (prev) dbl++;
                t[nacks] = cyc_i;
                nacks++;
                prev = 1'b1;
            end else begin
                prev = 1'b0;
            end
        end
        @(negedge clock);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(posedge clock); #1;
        check("stream_last_ack_width", ack[1], 0);
        check("stream_ack_count", nacks, 3);
        check("stream_first_latency", t[0], 4);
        check("stream_spacing_1", t[1] - t[0], 5);
        check("stream_spacing_2", t[2] - t[1], 5);
        check("stream_double_ack", dbl, 0);

        // Abort during wait
        wr(2, 32'h40, 32'h11110000, 4'hF, 6);
        @(negedge clock);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
        adr[2] = 32'h40; dat_w[2] = 32'hCAFEF00D; sel[2] = 4'hF;
        repeat (3) @(posedge clock);
        @(negedge clock);
        cyc[2] = 1'b0; stb[2] = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clock); #1;
            if (ack[2] || err[2]) seen++;
        end
        check("abort_no_response", seen, 0);
        rdchk(2, 32'h40, 32'h11110000, 6);

        // Asynchronous reset during wait
        wr(3, 32'h80, 32'h55AA55AA, 4'hF, 5);
        rdchk(3, 32'h80, 32'h55AA55AA, 5);
        @(negedge clock);
        cyc[3] = 1'b1; stb[3] = 1'b1; we[3] = 1'b0; adr[3] = 32'h80; sel[3] = 4'hF;
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_ack", ack[3], 0);
        check("async_reset_err", err[3], 0);
        check("async_reset_dat_r", dat_r[3], 0);
        cyc[3] = 1'b0; stb[3] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        rdchk(3, 32'h80, 32'h55AA55AA, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_sram_target.md
Name: wb_sram_target

Overview:
- Single-clock Wishbone classic responder backed by an internal word-addressed RAM.
- Terminates the target end of a Wishbone link, for example the target-side port of the clock-domain bridge or any initiator.
- Supports byte-lane writes, a programmable number of wait states, and an error response for out-of-range addresses.
- Used as the standalone synthesizable target in bridge/interconnect benches and as on-chip scratch RAM.

Parameters:
- ADR_WIDTH, 32, byte-address width of adr.
- DAT_WIDTH, 32, data width; must be 8, 16, 32 or 64. Lane count NLANES = DAT_WIDTH/8.
- DEPTH, 1024, number of DAT_WIDTH words.
- WAIT_STATES, 0, extra cycles inserted between request acceptance and ack/err; range 0..15.

Ports:
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- adr  in  ADR_WIDTH  byte address.
- dat_w  in  DAT_WIDTH  write data.
- dat_r  out  DAT_WIDTH  read data; valid when ack=1.
- cyc  in  1  bus cycle active.
- stb  in  1  strobe.
- we  in  1  1 = write, 0 = read.
- sel  in  NLANES  byte-lane enables.
- ack  out  1  normal termination.
- err  out  1  error termination.

Behaviour:
- Reset is asynchronous, active-high. While reset=1 and on release: state=IDLE, ack=0, err=0, dat_r=0, wait counter=0. RAM contents are not reset.
- Word index = adr >> log2(NLANES). Low address bits are ignored; misalignment is not an error. Access is out-of-range when index >= DEPTH.
- States:
  - IDLE: if cyc&stb on a rising edge, capture adr/we/sel/dat_w. Go to WAIT if WAIT_STATES>0, else RESP. Load counter with WAIT_STATES-1.
  - WAIT: decrement the counter each cycle. When counter==0, go to RESP.
  - RESP: assert ack (or err) for exactly one cycle, then go to IDLE.
  - The ack/err register is set on the edge that enters RESP. Entering RESP performs the access:
    - In-range write: lanes with sel[i]=1 are written; lanes with sel=0 are untouched.
    - In-range read: dat_r loads RAM[index] (all lanes, regardless of sel).
    - Out-of-range: err=1, ack=0, no RAM change, dat_r=0.
- Latency: ack/err rises WAIT_STATES+1 cycles after the edge that samples cyc&stb. Minimum is 1 cycle (WAIT_STATES=0).
- ack and err are never both 1. Each asserts for exactly one cycle per transfer.
- Back-to-back: if stb stays high after ack, the next request is sampled in the IDLE cycle after RESP. Throughput is one transfer per WAIT_STATES+2 cycles. There is no double-ack on a held stb.
- dat_r holds its last value outside ack. It is only meaningful while ack=1.
- Abort: if cyc drops while in WAIT, return to IDLE next edge. No ack/err is issued and a pending write is discarded.
- Inputs are captured at acceptance. Changes on adr/dat_w/sel/we during WAIT are ignored.
- sel=0 on a write: ack is issued and the RAM is unchanged.

Decomposition:
- Package wb_sram_target_pkg:
  - state enum (IDLE, WAIT, RESP);
  - a function computing the index shift from DAT_WIDTH;
  - the WAIT_STATES counter width constant (4).
- Sub-module wb_sram_target_mem: single-port RAM with per-lane write enables and a registered read (DEPTH, DAT_WIDTH parameters). The top holds the FSM, capture registers and range check.

Test Plan:
- Defaults, WAIT_STATES=0. Write adr=0x10, dat_w=0xDEADBEEF, sel=4'hF, then read adr=0x10 -> ack exactly 1 cycle after each stb sample; read returns dat_r=0xDEADBEEF; err never asserts.
- Byte lanes. Write 0x11223344 to adr=0x20 with sel=F, then write 0xAABBCCDD with sel=4'b0101, then read -> dat_r=0x11BB33DD.
- WAIT_STATES=3. Read adr=0x10 -> ack rises 4 cycles after acceptance. Holding stb high for 3 reads gives acks spaced 5 cycles apart, each exactly 1 cycle wide.
- Out-of-range, DEPTH=1024. Write to adr=0x1000 (index 1024) -> err=1 for 1 cycle, ack=0. A following read of adr=0x0 returns the prior contents, unchanged.
- Abort, WAIT_STATES=5. Start a write of 0xCAFEF00D to adr=0x40, drop cyc after 2 cycles -> no ack/err, FSM in IDLE. Read adr=0x40 -> old value.
- Reset mid-operation, WAIT_STATES=4. Assert reset asynchronously (between edges) during WAIT -> ack/err/dat_r go to 0 immediately. After release, a new read completes normally with latency 5.
